// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit layout, node/packet IDs, packet length width,
// transmit scheduler state encoding, and the header-to-length decode helper.
package chiplet_types_pkg;

  localparam int NODE_ID_WIDTH    = 4;
  localparam int PKT_ID_WIDTH     = 4;
  localparam int VC_WIDTH         = 2;
  localparam int PKT_LENGTH_WIDTH = 8;

  typedef logic [NODE_ID_WIDTH-1:0]    node_id_t;
  typedef logic [PKT_ID_WIDTH-1:0]     pkt_id_t;
  typedef logic [VC_WIDTH-1:0]         vc_id_t;
  typedef logic [PKT_LENGTH_WIDTH-1:0] pkt_len_t;

  typedef struct packed {
    vc_id_t      vc;
    pkt_id_t     id;
    node_id_t    req;
    logic [31:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH_HDR,
    ST_SEND,
    ST_DONE
  } tx_state_t;

  // The length field of a header word counts flits including the header
  // itself. A zero field is treated as a header-only packet so the sender
  // can never stall on a zero-length transfer.
  function automatic pkt_len_t expected_num_flits(input pkt_len_t len_field);
    pkt_len_t len;
    len = len_field;
    if (len == '0) len = pkt_len_t'(1);
    return len;
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Credit counter for one virtual channel.
// Ports:
//   clk, rst  - clock, async active-high reset (reloads to DEPTH)
//   consume   - a flit transferred on this VC this cycle
//   returned  - the downstream buffer freed one slot this cycle
//   credit    - credits currently available, 0..DEPTH
module vc_credit_counter #(
  parameter int DEPTH = 8,
  localparam int W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         consume,
  input  logic         returned,
  output logic [W-1:0] credit
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  // A consume and a return in the same cycle cancel. A return at FULL is
  // dropped and a consume at zero is ignored, so the count stays in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= FULL;
    end else if (consume && !returned) begin
      if (credit != '0) credit <= credit - W'(1);
    end else if (returned && !consume) begin
      if (credit != FULL) credit <= credit + W'(1);
    end
  end

endmodule

// File: rtl/tx_sched_fsm.sv
// Transmit scheduler: picks a pending message slot round-robin, reads its
// header to learn the packet length, then streams the packet words out of
// packet memory as flits, gated by per-VC credits.
// Ports:
//   clk, rst             - clock, async active-high reset
//   node_id              - local node ID placed in every flit
//   trigger_send         - per-slot send request pulse
//   pkt_start_addr       - per-slot packet base address (word aligned)
//   msg_vc               - per-slot virtual channel
//   bus_ren/bus_addr     - packet memory read request and address
//   bus_rdata            - read data, valid when ren=1 and stall=0
//   bus_request_stall    - memory stall
//   flit_valid/flit_out  - flit offered to the switch
//   flit_ready           - switch accepts the flit this cycle
//   credit_return        - one credit back per set bit
//   done_valid/done_id   - one-cycle completion pulse for a slot
//   busy                 - FSM is not idle
module tx_sched_fsm
  import chiplet_types_pkg::*;
#(
  parameter int NUM_MSGS = 4,
  parameter int NUM_VCS  = 2,
  parameter int DEPTH    = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  node_id_t                                  node_id,
  input  logic [NUM_MSGS-1:0]                       trigger_send,
  input  logic [NUM_MSGS-1:0][31:0]                 pkt_start_addr,
  input  logic [NUM_MSGS-1:0][$clog2(NUM_VCS)-1:0]  msg_vc,
  output logic                                      bus_ren,
  output logic [31:0]                               bus_addr,
  input  logic [31:0]                               bus_rdata,
  input  logic                                      bus_request_stall,
  output logic                                      flit_valid,
  output flit_t                                     flit_out,
  input  logic                                      flit_ready,
  input  logic [NUM_VCS-1:0]                        credit_return,
  output logic                                      done_valid,
  output pkt_id_t                                   done_id,
  output logic                                      busy
);

  localparam int SEL_W    = $clog2(NUM_MSGS);
  localparam int VC_SEL_W = $clog2(NUM_VCS);
  localparam int CREDIT_W = $clog2(DEPTH + 1);

  tx_state_t                          state;
  logic [NUM_MSGS-1:0]                pending;
  logic [NUM_MSGS-1:0]                sel_onehot;
  logic [SEL_W-1:0]                   sel;
  logic [SEL_W-1:0]                   last_served;
  logic [SEL_W-1:0]                   rr_pick;
  logic                               rr_found;
  pkt_len_t                           word_idx;
  pkt_len_t                           total;
  logic [NUM_VCS-1:0][CREDIT_W-1:0]   credit;
  logic [NUM_VCS-1:0]                 consume;
  logic [VC_SEL_W-1:0]                cur_vc;
  logic [31:0]                        cur_base;
  logic                               credit_ok;
  logic                               xfer;
  logic                               last_flit;

  assign cur_base  = pkt_start_addr[sel];
  assign cur_vc    = msg_vc[sel];
  assign credit_ok = (credit[cur_vc] != '0);
  assign xfer      = flit_valid && flit_ready;
  assign last_flit = (word_idx == total - pkt_len_t'(1));

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  // Round-robin search starting one past the last slot served.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 1; k <= NUM_MSGS; k++) begin
      idx = (int'(last_served) + k) % NUM_MSGS;
      if (!rr_found && pending[idx]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'(idx);
      end
    end
  end

  // Outputs decode from state and registered counters so a flit can go out
  // in the very first SEND cycle.
  always_comb begin
    busy       = (state != ST_IDLE);
    done_valid = (state == ST_DONE);
    done_id    = pkt_id_t'(sel);
    bus_ren    = 1'b0;
    bus_addr   = cur_base;
    flit_valid = 1'b0;
    case (state)
      ST_FETCH_HDR: bus_ren = 1'b1;
      ST_SEND: begin
        bus_ren    = (word_idx < total);
        bus_addr   = cur_base + (32'(word_idx) << 2);
        flit_valid = bus_ren && !bus_request_stall && credit_ok;
      end
      default: ;
    endcase
    flit_out.vc      = vc_id_t'(cur_vc);
    flit_out.id      = pkt_id_t'(sel);
    flit_out.req     = node_id;
    flit_out.payload = bus_rdata;
  end

  // A slot's pending bit stays set from trigger until its DONE cycle, so a
  // retrigger of a pending or in-flight slot simply merges into the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      sel         <= '0;
      last_served <= SEL_W'(NUM_MSGS - 1);
      word_idx    <= '0;
      total       <= '0;
    end else begin
      if (state == ST_DONE) pending <= (pending | trigger_send) & ~sel_onehot;
      else                  pending <= pending | trigger_send;
      case (state)
        ST_IDLE: begin
          if (rr_found) begin
            sel   <= rr_pick;
            state <= ST_FETCH_HDR;
          end
        end
        ST_FETCH_HDR: begin
          if (!bus_request_stall) begin
            total    <= expected_num_flits(bus_rdata[PKT_LENGTH_WIDTH-1:0]);
            word_idx <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            word_idx <= word_idx + pkt_len_t'(1);
            if (last_flit) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_served <= sel;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
    assign consume[v] = xfer && (cur_vc == VC_SEL_W'(v));
    vc_credit_counter #(.DEPTH(DEPTH)) u_credit (
      .clk      (clk),
      .rst      (rst),
      .consume  (consume[v]),
      .returned (credit_return[v]),
      .credit   (credit[v])
    );
  end

endmodule
